// File: rtl/dm_byteen_if.sv
// CPU data-port bundle between the M stage and the data-memory responder,
// carrying the load/store request, read data, store trace and fault report.
interface dm_byteen_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        dm_ready;
  logic        log_valid;
  logic [31:0] log_pc;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        dm_fault;
  logic [31:0] fault_pc;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    input  m_data_rdata, dm_ready, log_valid, log_pc, log_addr, log_data,
           dm_fault, fault_pc
  );

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    output m_data_rdata, dm_ready, log_valid, log_pc, log_addr, log_data,
           dm_fault, fault_pc
  );
endinterface

// File: rtl/dm_byteen_responder.sv
// Byte-enabled data memory: clears itself after reset, merges legal stores,
// serves combinational loads, and reports a store trace plus a sticky fault.
module dm_byteen_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  dm_byteen_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [31:0]         r_mem [DEPTH];
  logic                r_dm_ready;
  logic                r_log_valid;
  logic [31:0]         r_log_pc;
  logic [31:0]         r_log_addr;
  logic [31:0]         r_log_data;
  logic                r_dm_fault;
  logic [31:0]         r_fault_pc;

  logic [31:0]         w_offset;
  logic                w_in_range;
  logic [ADDR_W-1:0]   w_idx;
  logic [31:0]         w_old;
  logic [31:0]         w_merged;
  logic                w_store;
  logic                w_commit;
  logic                w_illegal;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_w[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Only naturally aligned word, halfword and byte lane patterns are accepted.
  function automatic logic legal_pattern(input logic [3:0] be,
                                         input logic [1:0] a);
    return ((be == 4'b1111) && (a == 2'd0)) ||
           ((be == (4'b0011 << a)) && !a[0]) ||
           (be == (4'b0001 << a));
  endfunction

  // Address decode, read-before-write lookup and store classification.
  always_comb begin
    w_offset   = bus.m_data_addr - BASE_ADDR;
    w_in_range = (w_offset[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});
    w_idx      = w_offset[ADDR_W+1:2];
    w_old      = r_mem[w_idx];
    w_merged   = merge_lanes(w_old, bus.m_data_wdata, bus.m_data_byteen);
    w_store    = (r_state == ST_READY) && (bus.m_data_byteen != 4'b0000);
    w_commit   = w_store && w_in_range && legal_pattern(bus.m_data_byteen, w_offset[1:0]);
    w_illegal  = w_store && !w_commit;
    if ((r_state == ST_READY) && w_in_range) begin
      bus.m_data_rdata = w_old;
    end else begin
      bus.m_data_rdata = 32'h0000_0000;
    end
  end

  // Clear/ready sequencing, store trace and first-fault capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_CLEAR;
      r_clr_cnt   <= {ADDR_W{1'b0}};
      r_dm_ready  <= 1'b0;
      r_log_valid <= 1'b0;
      r_log_pc    <= 32'h0000_0000;
      r_log_addr  <= 32'h0000_0000;
      r_log_data  <= 32'h0000_0000;
      r_dm_fault  <= 1'b0;
      r_fault_pc  <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_log_valid <= 1'b0;
          r_clr_cnt   <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == {ADDR_W{1'b1}}) begin
            r_state    <= ST_READY;
            r_dm_ready <= 1'b1;
          end
        end
        ST_READY: begin
          r_log_valid <= w_commit;
          if (w_commit) begin
            r_log_pc   <= bus.m_inst_addr;
            r_log_addr <= {bus.m_data_addr[31:2], 2'b00};
            r_log_data <= w_merged;
          end
          if (w_illegal && !r_dm_fault) begin
            r_dm_fault <= 1'b1;
            r_fault_pc <= bus.m_inst_addr;
          end
        end
        default: begin
          r_state     <= ST_CLEAR;
          r_clr_cnt   <= {ADDR_W{1'b0}};
          r_dm_ready  <= 1'b0;
          r_log_valid <= 1'b0;
        end
      endcase
    end
  end

  // Single write port: zero fill while clearing, merged store once ready.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_cnt] <= 32'h0000_0000;
    end else if (w_commit) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign bus.dm_ready  = r_dm_ready;
  assign bus.log_valid = r_log_valid;
  assign bus.log_pc    = r_log_pc;
  assign bus.log_addr  = r_log_addr;
  assign bus.log_data  = r_log_data;
  assign bus.dm_fault  = r_dm_fault;
  assign bus.fault_pc  = r_fault_pc;
endmodule

// File: tb/tb_dm_byteen_responder.sv
// Scoreboard bench for dm_byteen_responder: a word-array model predicts read
// data, trace records (queued at store time) and the sticky fault report.
module tb_dm_byteen_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_byteen_if bus();
  dm_byteen_responder dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  int          n_vec = 0;
  int          n_err = 0;
  rec_t        expq[$];
  logic [31:0] mdl [int];
  bit          exp_fault = 1'b0;
  logic [31:0] exp_fault_pc = 32'h0;

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'h0000_4000;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    if (!in_rng(a)) return 32'h0;
    if (mdl.exists(int'(a >> 2))) return mdl[int'(a >> 2)];
    return 32'h0;
  endfunction

  function automatic bit lane_ok(input logic [3:0] be, input logic [1:0] a);
    case (be)
      4'b1111: return a == 2'd0;
      4'b0011: return a == 2'd0;
      4'b1100: return a == 2'd2;
      4'b0001: return a == 2'd0;
      4'b0010: return a == 2'd1;
      4'b0100: return a == 2'd2;
      4'b1000: return a == 2'd3;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_read(input logic [31:0] addr);
    rec_t r;
    bus.m_data_addr   = addr;
    bus.m_data_byteen = 4'b0000;
    @(negedge clk);
    if (bus.log_valid === 1'b1) begin
      n_vec++;
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL log_unexpected: got pc=%h addr=%h data=%h, required no log",
                 bus.log_pc, bus.log_addr, bus.log_data);
      end else begin
        r = expq.pop_front();
        if ({bus.log_pc, bus.log_addr, bus.log_data} !== {r.pc, r.addr, r.data}) begin
          n_err++;
          $display("FAIL log_record: got pc=%h addr=%h data=%h, required pc=%h addr=%h data=%h",
                   bus.log_pc, bus.log_addr, bus.log_data, r.pc, r.addr, r.data);
        end
      end
    end
    n_vec++;
    if (bus.m_data_rdata !== mdl_rd(addr)) begin
      n_err++;
      $display("FAIL read @%h: got %h, required %h", addr, bus.m_data_rdata, mdl_rd(addr));
    end
    @(posedge clk); #1;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] pc);
    logic [31:0] old_w, merged;
    bit          ok;
    rec_t        r;
    old_w  = mdl_rd(addr);
    ok     = lane_ok(be, addr[1:0]) && in_rng(addr);
    merged = old_w;
    for (int k = 0; k < 4; k++) if (be[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    bus.m_data_addr   = addr;
    bus.m_data_wdata  = wdata;
    bus.m_data_byteen = be;
    bus.m_inst_addr   = pc;
    if (ok) begin
      r.pc = pc; r.addr = {addr[31:2], 2'b00}; r.data = merged;
      expq.push_back(r);
    end else if (!exp_fault) begin
      exp_fault    = 1'b1;
      exp_fault_pc = pc;
    end
    @(negedge clk);
    if (bus.log_valid === 1'b1) begin
      n_vec++;
      if (expq.size() == 0 || (ok && expq.size() == 1)) begin
        n_err++;
        $display("FAIL log_unexpected: got pc=%h addr=%h data=%h, required no log",
                 bus.log_pc, bus.log_addr, bus.log_data);
      end else begin
        r = expq.pop_front();
        if ({bus.log_pc, bus.log_addr, bus.log_data} !== {r.pc, r.addr, r.data}) begin
          n_err++;
          $display("FAIL log_record: got pc=%h addr=%h data=%h, required pc=%h addr=%h data=%h",
                   bus.log_pc, bus.log_addr, bus.log_data, r.pc, r.addr, r.data);
        end
      end
    end
    n_vec++;
    if (bus.m_data_rdata !== old_w) begin
      n_err++;
      $display("FAIL same_cycle_read @%h: got %h, required %h", addr, bus.m_data_rdata, old_w);
    end
    @(posedge clk); #1;
    bus.m_data_byteen = 4'b0000;
    if (ok) mdl[int'(addr >> 2)] = merged;
    n_vec++;
    if (bus.dm_fault !== exp_fault || (exp_fault && bus.fault_pc !== exp_fault_pc)) begin
      n_err++;
      $display("FAIL fault_state pc=%h: got fault=%b fault_pc=%h, required fault=%b fault_pc=%h",
               pc, bus.dm_fault, bus.fault_pc, exp_fault, exp_fault_pc);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.m_data_addr = 32'h0; bus.m_data_wdata = 32'h0;
    bus.m_data_byteen = 4'b0000; bus.m_inst_addr = 32'h0;
    @(negedge clk);
    n_vec++;
    if ({bus.dm_ready, bus.log_valid, bus.dm_fault} !== 3'b000 || bus.fault_pc !== 32'h0 ||
        bus.m_data_rdata !== 32'h0 || bus.log_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: got ready=%b log_valid=%b fault=%b fault_pc=%h rdata=%h log_data=%h, required all zero",
               bus.dm_ready, bus.log_valid, bus.dm_fault, bus.fault_pc, bus.m_data_rdata, bus.log_data);
    end
    #10 reset = 1'b0;
  endtask

  // Counts edges from reset release to dm_ready; also pokes a store mid-clear.
  task automatic test_clear(input string tag);
    int cnt = 0;
    while (bus.dm_ready !== 1'b1 && cnt < 5000) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 10) begin
        bus.m_data_addr = 32'h8; bus.m_data_wdata = 32'hFFFF_FFFF;
        bus.m_data_byteen = 4'b1111; bus.m_inst_addr = 32'h100;
      end
      if (cnt == 11) begin
        n_vec++;
        if (bus.m_data_rdata !== 32'h0 || bus.log_valid !== 1'b0 || bus.dm_fault !== 1'b0) begin
          n_err++;
          $display("FAIL %s_store_in_clear: got rdata=%h log_valid=%b fault=%b, required 0 0 0",
                   tag, bus.m_data_rdata, bus.log_valid, bus.dm_fault);
        end
        bus.m_data_byteen = 4'b0000;
      end
    end
    n_vec++;
    if (cnt != 4096) begin
      n_err++;
      $display("FAIL %s_ready_latency: got %0d cycles, required 4096", tag, cnt);
    end
    n_vec++;
    if (bus.dm_fault !== 1'b0) begin
      n_err++;
      $display("FAIL %s_fault_after_clear: got %b, required 0", tag, bus.dm_fault);
    end
    do_read(32'h8);
    do_read(32'h10);
  endtask

  task automatic test_store_merge;
    do_store(32'h10, 32'h1234_5678, 4'b1111, 32'h1000);
    do_store(32'h12, 32'h00AB_0000, 4'b0100, 32'h1004);
    do_read(32'h10);
    n_vec++;
    if (bus.m_data_rdata !== 32'h12AB_5678) begin
      n_err++;
      $display("FAIL merge_word: got %h, required 12ab5678", bus.m_data_rdata);
    end
  endtask

  task automatic test_halfword;
    do_store(32'h22, 32'hBEEF_0000, 4'b1100, 32'h1008);
    do_read(32'h20);
  endtask

  task automatic test_fault;
    do_store(32'h21, 32'h0000_1111, 4'b0011, 32'h3040);
    do_read(32'h20);
    do_store(32'h21, 32'h2222_2222, 4'b1111, 32'h3050);
    do_store(32'h24, 32'h0000_0033, 4'b0101, 32'h3054);
    do_read(32'h24);
  endtask

  task automatic test_back_to_back;
    logic [3:0]  be_tab [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [1:0]  a_tab  [7] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    int          k;
    logic [31:0] a;
    do_store(32'h30, 32'h0000_0011, 4'b0001, 32'h2000);
    do_store(32'h31, 32'h0000_2200, 4'b0010, 32'h2004);
    do_store(32'h32, 32'h3344_0000, 4'b1100, 32'h2008);
    do_read(32'h30);
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 6);
      a = {22'h0, 8'($urandom_range(64, 71)), a_tab[k]};
      do_store(a, $urandom, be_tab[k], 32'h2100 + 32'(4 * i));
    end
    for (int w = 64; w < 72; w++) do_read(32'(w * 4));
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.dm_ready !== 1'b0 || bus.log_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got ready=%b log_valid=%b, required 0 0", bus.dm_ready, bus.log_valid);
    end
    mdl.delete();
    exp_fault = 1'b0;
    exp_fault_pc = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_clear("mid");
    do_store(32'h3FFC, 32'hCAFE_F00D, 4'b1111, 32'h4000);
    do_read(32'h3FFC);
    do_store(32'h4000, 32'hDEAD_BEEF, 4'b1111, 32'h4004);
    do_read(32'h4000);
    do_read(32'h0);
  endtask

  initial begin
    test_reset();
    test_clear("first");
    test_store_merge();
    test_halfword();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    n_vec++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL log_missing: got %0d unmatched records, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
